// File: rtl/eq_mgt_pkg.sv
// eq_mgt_pkg
//   Shared definitions for the multi-channel EQ producer-index manager.
//   Default widths, response field offsets, and the full-EQ compare.
//   Response head layout: {full, eqn, pi}.
package eq_mgt_pkg;

    localparam int NUM_CH_DEF      = 3;
    localparam int NUM_EQ_DEF      = 16;
    localparam int EQN_W_DEF       = 4;
    localparam int DEPTH_LOG_DEF   = 8;
    localparam int PI_W_DEF        = DEPTH_LOG_DEF + 1;
    localparam int REQ_HEAD_W_DEF  = 32;
    localparam int RESP_HEAD_W_DEF = 1 + EQN_W_DEF + PI_W_DEF;

    localparam int RESP_PI_LSB   = 0;
    localparam int RESP_EQN_LSB  = PI_W_DEF;
    localparam int RESP_FULL_BIT = PI_W_DEF + EQN_W_DEF;

    // The EQ is full when the producer is exactly one depth ahead of the
    // consumer. Only equality is tested, so an illegal CI that puts the
    // distance beyond the depth is never reported as full.
    function automatic logic eq_full(input logic [31:0] pi, input logic [31:0] ci,
                                     input int pi_w, input int depth_log);
        logic [31:0] mask;
        mask = (32'd1 << pi_w) - 32'd1;
        return ((pi - ci) & mask) == (32'd1 << depth_log);
    endfunction

endpackage

// File: rtl/eq_mgt_rr_arb.sv
// eq_mgt_rr_arb
//   Rotating-priority arbiter: grants at most one eligible requester per
//   cycle, searching from ptr; after a grant to c the pointer moves to c+1.
// Ports
//   clk, rst_n : clock, async active-low reset
//   req_i      : per-channel eligibility
//   grant_o    : one-hot (or zero) grant
module eq_mgt_rr_arb
    import eq_mgt_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req_i,
    output logic [NUM_CH-1:0] grant_o
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               idx;

    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                ptr_d        = (idx == NUM_CH - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/eq_mgt_mc.sv
// eq_mgt_mc
//   Multi-channel EQ producer-index manager. Each channel requests the next
//   slot of an EQ; one round-robin grant per cycle; returns {full, eqn, pi}
//   one cycle later and holds it until accepted. Software writes CI.
// Ports
//   clk, rst_n                : clock, async active-low reset
//   req_valid/req_head/req_ready    : per-channel request (eqn in low bits)
//   resp_valid/resp_head/resp_ready : per-channel response {full, eqn, pi}
//   ci_wr_valid/ci_wr_eqn/ci_wr_idx : consumer-index update
//   ovf_pulse/ovf_eqn         : request hit a full EQ; last overflowing EQ
module eq_mgt_mc
    import eq_mgt_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int NUM_EQ      = NUM_EQ_DEF,
    parameter int EQN_W       = EQN_W_DEF,
    parameter int DEPTH_LOG   = DEPTH_LOG_DEF,
    parameter int PI_W        = DEPTH_LOG + 1,
    parameter int REQ_HEAD_W  = REQ_HEAD_W_DEF,
    parameter int RESP_HEAD_W = 1 + EQN_W + PI_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH-1:0]             req_valid,
    input  logic [NUM_CH*REQ_HEAD_W-1:0]  req_head,
    output logic [NUM_CH-1:0]             req_ready,
    output logic [NUM_CH-1:0]             resp_valid,
    output logic [NUM_CH*RESP_HEAD_W-1:0] resp_head,
    input  logic [NUM_CH-1:0]             resp_ready,
    input  logic                          ci_wr_valid,
    input  logic [EQN_W-1:0]              ci_wr_eqn,
    input  logic [PI_W-1:0]               ci_wr_idx,
    output logic                          ovf_pulse,
    output logic [EQN_W-1:0]              ovf_eqn
);

    logic [PI_W-1:0]        pi_q [NUM_EQ];
    logic [PI_W-1:0]        ci_q [NUM_EQ];
    logic [NUM_CH-1:0]      resp_valid_q;
    logic [RESP_HEAD_W-1:0] resp_head_q [NUM_CH];
    logic                   ovf_pulse_q;
    logic [EQN_W-1:0]       ovf_eqn_q;

    logic [NUM_CH-1:0]      eligible;
    logic [NUM_CH-1:0]      grant;
    logic                   any_gnt;
    logic [EQN_W-1:0]       g_eqn;
    logic [PI_W-1:0]        g_pi;
    logic                   g_full;
    logic [PI_W-1:0]        pi_d;
    logic                   unused_head;

    // A channel may be granted only if its single response slot frees up
    // by the next edge; this keeps at most one response outstanding.
    assign eligible = req_valid & (~resp_valid_q | resp_ready);

    eq_mgt_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (eligible),
        .grant_o (grant)
    );

    assign req_ready = grant;
    assign any_gnt   = |grant;

    always_comb begin
        g_eqn = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) g_eqn = req_head[c*REQ_HEAD_W +: EQN_W];
        end
    end

    // Full compare uses registered CI, so a same-cycle CI write is not seen.
    assign g_pi   = pi_q[g_eqn];
    assign g_full = eq_full(32'(g_pi), 32'(ci_q[g_eqn]), PI_W, DEPTH_LOG);
    assign pi_d   = g_pi + PI_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NUM_EQ; e++) begin
                pi_q[e] <= '0;
                ci_q[e] <= '0;
            end
            for (int c = 0; c < NUM_CH; c++) resp_head_q[c] <= '0;
            resp_valid_q <= '0;
            ovf_pulse_q  <= 1'b0;
            ovf_eqn_q    <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (grant[c]) begin
                    resp_valid_q[c] <= 1'b1;
                    resp_head_q[c]  <= {g_full, g_eqn, g_pi};
                end else if (resp_ready[c]) begin
                    resp_valid_q[c] <= 1'b0;
                end
            end
            if (any_gnt && !g_full) pi_q[g_eqn] <= pi_d;
            if (ci_wr_valid) ci_q[ci_wr_eqn] <= ci_wr_idx;
            ovf_pulse_q <= any_gnt & g_full;
            if (any_gnt && g_full) ovf_eqn_q <= g_eqn;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_resp
        assign resp_head[c*RESP_HEAD_W +: RESP_HEAD_W] = resp_head_q[c];
    end

    assign resp_valid  = resp_valid_q;
    assign ovf_pulse   = ovf_pulse_q;
    assign ovf_eqn     = ovf_eqn_q;
    assign unused_head = ^req_head;

endmodule

// File: tb/tb_eq_mgt_mc.sv
module tb_eq_mgt_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req_valid;
    logic [95:0] req_head;
    logic [2:0]  req_ready;
    logic [2:0]  resp_valid;
    logic [41:0] resp_head;
    logic [2:0]  resp_ready;
    logic        ci_wr_valid;
    logic [3:0]  ci_wr_eqn;
    logic [8:0]  ci_wr_idx;
    logic        ovf_pulse;
    logic [3:0]  ovf_eqn;

    eq_mgt_mc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_head    (req_head),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_head   (resp_head),
        .resp_ready  (resp_ready),
        .ci_wr_valid (ci_wr_valid),
        .ci_wr_eqn   (ci_wr_eqn),
        .ci_wr_idx   (ci_wr_idx),
        .ovf_pulse   (ovf_pulse),
        .ovf_eqn     (ovf_eqn)
    );

    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_tot  = 0;
    int          n_fail = 0;

    // reference model and scoreboard
    logic [8:0]  pi_m [16];
    logic [8:0]  ci_m [16];
    int          ptr_m;
    logic        ovf_exp;
    logic [3:0]  ovf_eqn_m;
    logic [13:0] q [3][$];
    logic [2:0]  obs_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tot++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_eqn(input int c, input logic [3:0] e);
        req_head[c*32 +: 32] = {28'hABCDEF0, e};
    endtask

    task automatic model_reset();
        for (int e = 0; e < 16; e++) begin
            pi_m[e] = '0;
            ci_m[e] = '0;
        end
        for (int c = 0; c < 3; c++) q[c].delete();
        ptr_m     = 0;
        ovf_exp   = 1'b0;
        ovf_eqn_m = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_ovf_pulse", ovf_pulse, 0);
        chk("rst_ovf_eqn", ovf_eqn, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One clock: check responses and overflow against the scoreboard,
    // predict the grant, push the expected response, update the model.
    task automatic cycle();
        int         g;
        logic [2:0] eg;
        logic [3:0] e;
        logic [8:0] diff;
        logic       fl;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            chk("resp_valid", resp_valid[c], q[c].size() > 0);
            if (q[c].size() > 0) begin
                chk("resp_head", resp_head[c*14 +: 14], q[c][0]);
                if (resp_ready[c]) void'(q[c].pop_front());
            end
        end
        chk("ovf_pulse", ovf_pulse, ovf_exp);
        chk("ovf_eqn", ovf_eqn, ovf_eqn_m);
        g = -1;
        for (int i = 0; i < 3; i++) begin
            int c;
            c = (ptr_m + i) % 3;
            if (g < 0 && req_valid[c] && q[c].size() == 0) g = c;
        end
        eg = (g >= 0) ? (3'b001 << g) : 3'b000;
        obs_rdy = req_ready;
        chk("req_ready", req_ready, eg);
        ovf_exp = 1'b0;
        if (g >= 0) begin
            e    = req_head[g*32 +: 4];
            diff = pi_m[e] - ci_m[e];
            fl   = (diff == 9'd256);
            q[g].push_back({fl, e, pi_m[e]});
            if (!fl) pi_m[e] = pi_m[e] + 9'd1;
            ovf_exp = fl;
            if (fl) ovf_eqn_m = e;
            ptr_m = (g + 1) % 3;
        end
        if (ci_wr_valid) ci_m[ci_wr_eqn] = ci_wr_idx;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        req_valid   = '0;
        req_head    = '0;
        resp_ready  = '0;
        ci_wr_valid = 1'b0;
        ci_wr_eqn   = '0;
        ci_wr_idx   = '0;
        rst_n       = 1'b1;
        @(posedge clk);
        #1;

        // reset state and first accepts on eqn 2
        do_reset();
        req_valid  = 3'b001;
        resp_ready = 3'b111;
        set_eqn(0, 4'd2);
        cycle();
        chk("t1_valid0", resp_valid[0], 1);
        chk("t1_head0", resp_head[13:0], {1'b0, 4'd2, 9'd0});
        cycle();
        chk("t1_head1", resp_head[13:0], {1'b0, 4'd2, 9'd1});
        cycle();
        chk("t1_head2", resp_head[13:0], {1'b0, 4'd2, 9'd2});
        req_valid = 3'b000;
        cycle();

        // round-robin from a fresh reset
        do_reset();
        resp_ready = 3'b111;
        req_valid  = 3'b111;
        for (int c = 0; c < 3; c++) set_eqn(c, 4'd3);
        cycle();
        chk("t2_gnt0", obs_rdy, 3'b001);
        cycle();
        chk("t2_gnt1", obs_rdy, 3'b010);
        chk("t2_head_ch0", resp_head[13:0], {1'b0, 4'd3, 9'd0});
        cycle();
        chk("t2_gnt2", obs_rdy, 3'b100);
        chk("t2_head_ch1", resp_head[27:14], {1'b0, 4'd3, 9'd1});
        cycle();
        chk("t2_gnt3", obs_rdy, 3'b001);
        chk("t2_head_ch2", resp_head[41:28], {1'b0, 4'd3, 9'd2});

        // backpressure on ch1
        resp_ready = 3'b101;
        set_eqn(1, 4'd7);
        cycle();
        chk("t5_gnt_ch1", obs_rdy, 3'b010);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t5_ch1_blocked", obs_rdy[1], 0);
        end
        chk("t5_hold_valid", resp_valid[1], 1);
        chk("t5_hold_head", resp_head[27:14], {1'b0, 4'd7, 9'd0});
        req_valid  = 3'b000;
        resp_ready = 3'b111;
        repeat (2) cycle();

        // fill eqn 5 to full
        req_valid = 3'b001;
        set_eqn(0, 4'd5);
        for (int i = 0; i < 256; i++) cycle();
        chk("t3_last_ok", resp_head[13:0], {1'b0, 4'd5, 9'd255});
        cycle();
        chk("t3_full_head", resp_head[13:0], {1'b1, 4'd5, 9'd256});
        chk("t3_ovf_pulse", ovf_pulse, 1);
        chk("t3_ovf_eqn", ovf_eqn, 5);
        req_valid   = 3'b000;
        ci_wr_valid = 1'b1;
        ci_wr_eqn   = 4'd5;
        ci_wr_idx   = 9'd1;
        cycle();
        ci_wr_valid = 1'b0;
        chk("t3_ovf_drop", ovf_pulse, 0);
        chk("t3_ovf_eqn_hold", ovf_eqn, 5);
        req_valid = 3'b001;
        cycle();
        chk("t3_after_ci", resp_head[13:0], {1'b0, 4'd5, 9'd256});
        chk("t3_slot0", resp_head[7:0], 8'd0);

        // same-cycle CI write on a full EQ sees the old CI
        ci_wr_valid = 1'b1;
        ci_wr_eqn   = 4'd5;
        ci_wr_idx   = 9'd2;
        cycle();
        ci_wr_valid = 1'b0;
        chk("t6_conservative", resp_head[13:0], {1'b1, 4'd5, 9'd257});
        chk("t6_ovf", ovf_pulse, 1);
        cycle();
        chk("t6_next_ok", resp_head[13:0], {1'b0, 4'd5, 9'd257});
        req_valid = 3'b000;
        cycle();

        // ramp eqn 1 to PI=511, then wrap
        req_valid = 3'b001;
        set_eqn(0, 4'd1);
        ci_wr_valid = 1'b1;
        ci_wr_eqn   = 4'd1;
        for (int i = 0; i < 511; i++) begin
            ci_wr_idx = pi_m[1];
            cycle();
        end
        req_valid = 3'b000;
        ci_wr_idx = 9'd511;
        cycle();
        ci_wr_valid = 1'b0;
        req_valid   = 3'b001;
        cycle();
        chk("t4_pi511", resp_head[13:0], {1'b0, 4'd1, 9'd511});
        chk("t4_slot255", resp_head[7:0], 8'd255);
        cycle();
        chk("t4_pi0", resp_head[13:0], {1'b0, 4'd1, 9'd0});
        chk("t4_slot0", resp_head[7:0], 8'd0);

        req_valid = 3'b000;
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
